vanilla_remote_req_responder: RTL and testbench

- Target-side endpoint for vanilla-core remote traffic: accepts `remote_req_s` packets arriving from the network, services them against a local single-port word SRAM, and returns `remote_load_resp_s` packets for loads and AMOs.
- Sits between the network endpoint and a tile-local memory (DMEM or scratchpad). It is the responder counterpart of the core's remote-request issue path.
- One request is outstanding at a time. AMOs are performed as an atomic read-modify-write.

---
 rtl/bsg_vanilla_pkg.sv | 50 +++++
 rtl/bsg_two_fifo.sv | 46 ++++
 rtl/vanilla_remote_req_responder.sv | 168 ++++++++++++++++
 tb/tb_vanilla_remote_req_responder.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_vanilla_pkg.sv
// Shared vanilla-core remote packet types plus the responder FSM state encoding
// (kept here so the debug trace can decode it).
package bsg_vanilla_pkg;

  localparam int RV32_reg_data_width_gp = 32;
  localparam int RV32_reg_addr_width_gp = 5;

  typedef enum logic [1:0] {
    e_vanilla_amoswap = 2'b00,
    e_vanilla_amoor   = 2'b01,
    e_vanilla_amoadd  = 2'b10
  } bsg_vanilla_amo_type_e;

  typedef struct packed {
    logic       float_wb;
    logic       is_unsigned_op;
    logic       is_byte_op;
    logic       is_hex_op;
    logic [1:0] part_sel;
  } load_info_s;

  typedef struct packed {
    logic                                write_not_read;
    logic                                is_amo_op;
    logic                                is_uncached_op;
    bsg_vanilla_amo_type_e               amo_type;
    logic [3:0]                          mask;
    load_info_s                          load_info;
    logic [RV32_reg_addr_width_gp-1:0]   reg_id;
    logic [RV32_reg_data_width_gp-1:0]   data;
    logic [31:0]                         addr;
  } remote_req_s;

  typedef struct packed {
    logic                                float_wb;
    logic                                is_unsigned_op;
    logic                                is_byte_op;
    logic                                is_hex_op;
    logic [1:0]                          part_sel;
    logic [RV32_reg_addr_width_gp-1:0]   reg_id;
    logic [RV32_reg_data_width_gp-1:0]   data;
  } remote_load_resp_s;

  typedef enum logic [1:0] {
    eIDLE    = 2'b00,
    eRD_WAIT = 2'b01,
    eAMO_WR  = 2'b10
  } vanilla_responder_state_e;

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry fall-through FIFO: data_o shows the head entry whenever v_o is high.
// Enqueue and dequeue may happen in the same cycle.
module bsg_two_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] r_mem [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic               w_enq;
  logic               w_deq;

  assign ready_o = (r_count != 2'd2);
  assign v_o     = (r_count != 2'd0);
  assign data_o  = r_mem[r_rd_ptr];
  assign w_enq   = v_i & ready_o;
  assign w_deq   = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_enq) r_wr_ptr <= ~r_wr_ptr;
      if (w_deq) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
    end
  end

  // Storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/vanilla_remote_req_responder.sv
// Target-side responder for remote requests: services stores, loads and AMOs
// against a single-port word SRAM and returns load/AMO responses in order.
module vanilla_remote_req_responder
  import bsg_vanilla_pkg::*;
#(
  parameter int mem_addr_width_p = 10,
  parameter int data_width_p     = RV32_reg_data_width_gp
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               req_v_i,
  input  logic [$bits(remote_req_s)-1:0]     req_i,
  output logic                               req_ready_o,
  output logic                               mem_v_o,
  output logic                               mem_w_o,
  output logic [mem_addr_width_p-1:0]        mem_addr_o,
  output logic [data_width_p-1:0]            mem_data_o,
  output logic [3:0]                         mem_mask_o,
  input  logic [data_width_p-1:0]            mem_data_i,
  output logic                               resp_v_o,
  output logic [$bits(remote_load_resp_s)-1:0] resp_o,
  input  logic                               resp_yumi_i,
  output logic                               store_ack_o
);

  remote_req_s               w_req;
  vanilla_responder_state_e  r_state;
  vanilla_responder_state_e  w_state_next;

  logic [RV32_reg_addr_width_gp-1:0] r_reg_id;
  load_info_s                        r_load_info;
  bsg_vanilla_amo_type_e             r_amo_type;
  logic [data_width_p-1:0]           r_data;
  logic [data_width_p-1:0]           r_old;
  logic [mem_addr_width_p-1:0]       r_addr;
  logic                              r_is_amo;
  logic                              r_store_ack;

  logic                              w_is_store;
  logic                              w_accept;
  logic [1:0]                        w_req_amo_bits;
  logic [data_width_p-1:0]           w_amo_new;
  logic                              w_enq_v;
  remote_load_resp_s                 w_resp_data;
  logic                              w_fifo_ready;
  logic                              w_fifo_v;
  logic [$bits(remote_load_resp_s)-1:0] w_fifo_data;
  logic                              w_unused;

  assign w_req          = req_i;
  assign w_req_amo_bits = w_req.amo_type;
  assign w_unused       = ^{w_req.is_uncached_op, w_req.addr};
  assign w_is_store     = w_req.write_not_read & ~w_req.is_amo_op;

  assign req_ready_o = reset_n_i & (r_state == eIDLE) & w_fifo_ready;
  assign w_accept    = req_v_i & req_ready_o;
  assign resp_v_o    = reset_n_i & w_fifo_v;
  assign resp_o      = w_fifo_data;
  assign store_ack_o = reset_n_i & r_store_ack;

  // Encoding 2'b11 is illegal and falls through to swap.
  always_comb begin
    w_amo_new = r_data;
    case (r_amo_type)
      e_vanilla_amoor:  w_amo_new = r_old | r_data;
      e_vanilla_amoadd: w_amo_new = r_old + r_data;
      default:          w_amo_new = r_data;
    endcase
  end

  always_comb begin
    w_state_next              = r_state;
    mem_v_o                   = 1'b0;
    mem_w_o                   = 1'b0;
    mem_addr_o                = r_addr;
    mem_data_o                = '0;
    mem_mask_o                = 4'h0;
    w_enq_v                   = 1'b0;
    w_resp_data.float_wb       = r_load_info.float_wb;
    w_resp_data.is_unsigned_op = r_load_info.is_unsigned_op;
    w_resp_data.is_byte_op     = r_load_info.is_byte_op;
    w_resp_data.is_hex_op      = r_load_info.is_hex_op;
    w_resp_data.part_sel       = r_load_info.part_sel;
    w_resp_data.reg_id         = r_reg_id;
    w_resp_data.data           = mem_data_i;
    if (!reset_n_i) begin
      w_state_next = eIDLE;
    end else begin
      case (r_state)
        eIDLE: begin
          if (w_accept) begin
            mem_v_o    = 1'b1;
            mem_addr_o = w_req.addr[2+:mem_addr_width_p];
            if (w_is_store) begin
              mem_w_o    = 1'b1;
              mem_data_o = w_req.data;
              mem_mask_o = w_req.mask;
            end else begin
              w_state_next = eRD_WAIT;
            end
          end
        end
        eRD_WAIT: begin
          if (r_is_amo) begin
            w_state_next = eAMO_WR;
          end else begin
            w_enq_v      = 1'b1;
            w_state_next = eIDLE;
          end
        end
        eAMO_WR: begin
          mem_v_o          = 1'b1;
          mem_w_o          = 1'b1;
          mem_data_o       = w_amo_new;
          mem_mask_o       = 4'hF;
          w_enq_v          = 1'b1;
          w_resp_data.data = r_old;
          w_state_next     = eIDLE;
        end
        default: w_state_next = eIDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state     <= eIDLE;
      r_store_ack <= 1'b0;
      r_is_amo    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_store_ack <= w_accept & w_is_store;
      if (w_accept & ~w_is_store) r_is_amo <= w_req.is_amo_op;
    end
  end

  // Captured request fields; only meaningful while a load/AMO is in flight.
  always_ff @(posedge clk_i) begin
    if (w_accept & ~w_is_store) begin
      r_reg_id    <= w_req.reg_id;
      r_load_info <= w_req.load_info;
      r_amo_type  <= w_req.amo_type;
      r_data      <= w_req.data;
      r_addr      <= w_req.addr[2+:mem_addr_width_p];
    end
    if (r_state == eRD_WAIT) r_old <= mem_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i && w_accept && w_req.is_amo_op) begin
      assert (w_req_amo_bits != 2'b11);
    end
  end

  bsg_two_fifo #(
    .width_p($bits(remote_load_resp_s))
  ) u_resp_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (w_enq_v),
    .data_i    (w_resp_data),
    .ready_o   (w_fifo_ready),
    .v_o       (w_fifo_v),
    .data_o    (w_fifo_data),
    .yumi_i    (resp_yumi_i)
  );

endmodule

// File: tb/tb_vanilla_remote_req_responder.sv
// Self-checking bench: SRAM environment model plus a word-level reference of
// memory contents and expected response order.
module tb_vanilla_remote_req_responder;
  import bsg_vanilla_pkg::*;

  localparam int REQ_W  = $bits(remote_req_s);
  localparam int RESP_W = $bits(remote_load_resp_s);

  logic              clk_i = 1'b0;
  logic              reset_n_i = 1'b0;
  logic              req_v_i = 1'b0;
  logic [REQ_W-1:0]  req_i;
  logic              req_ready_o;
  logic              mem_v_o;
  logic              mem_w_o;
  logic [9:0]        mem_addr_o;
  logic [31:0]       mem_data_o;
  logic [3:0]        mem_mask_o;
  logic [31:0]       mem_data_i;
  logic              resp_v_o;
  logic [RESP_W-1:0] resp_o;
  logic              resp_yumi_i = 1'b0;
  logic              store_ack_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  vanilla_remote_req_responder #(.mem_addr_width_p(10), .data_width_p(32)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .req_v_i(req_v_i), .req_i(req_i),
    .req_ready_o(req_ready_o), .mem_v_o(mem_v_o), .mem_w_o(mem_w_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_mask_o(mem_mask_o),
    .mem_data_i(mem_data_i), .resp_v_o(resp_v_o), .resp_o(resp_o),
    .resp_yumi_i(resp_yumi_i), .store_ack_o(store_ack_o)
  );

  remote_req_s cur_req = '0;
  assign req_i = cur_req;

  // SRAM environment with a backdoor write port for preloading.
  logic [31:0] sram [1024];
  logic [31:0] sram_rd = '0;
  logic        bd_we = 1'b0;
  logic [9:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;
  assign mem_data_i = sram_rd;

  always @(posedge clk_i) begin
    if (bd_we) sram[bd_addr] <= bd_data;
    else if (mem_v_o) begin
      if (mem_w_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_mask_o[b]) sram[mem_addr_o][8*b+:8] <= mem_data_o[8*b+:8];
      end else sram_rd <= sram[mem_addr_o];
    end
  end

  int ack_cnt = 0, acc_cnt = 0, bad_reset_wr = 0;
  always @(posedge clk_i) begin
    if (store_ack_o) ack_cnt++;
    if (req_v_i && req_ready_o) acc_cnt++;
    if (!reset_n_i && mem_v_o && mem_w_o) bad_reset_wr++;
  end

  // Reference model: word memory and queue of expected responses.
  logic [31:0]       ref_mem [1024];
  remote_load_resp_s exp_q [$];

  task automatic model_apply(input remote_req_s r);
    int unsigned       w;
    logic [31:0]       old;
    remote_load_resp_s e;
    w   = r.addr[11:2];
    old = ref_mem[w];
    e.float_wb = r.load_info.float_wb;  e.is_unsigned_op = r.load_info.is_unsigned_op;
    e.is_byte_op = r.load_info.is_byte_op; e.is_hex_op = r.load_info.is_hex_op;
    e.part_sel = r.load_info.part_sel;  e.reg_id = r.reg_id;  e.data = old;
    if (r.is_amo_op) begin
      if (r.amo_type == e_vanilla_amoor)       ref_mem[w] = old | r.data;
      else if (r.amo_type == e_vanilla_amoadd) ref_mem[w] = old + r.data;
      else                                     ref_mem[w] = r.data;
      exp_q.push_back(e);
    end else if (r.write_not_read) begin
      for (int b = 0; b < 4; b++) if (r.mask[b]) ref_mem[w][8*b+:8] = r.data[8*b+:8];
    end else exp_q.push_back(e);
  endtask

  function automatic remote_req_s mk(input logic wnr, input logic amo, input logic [1:0] at,
      input logic [3:0] mask, input logic [5:0] li, input logic [4:0] rid,
      input logic [31:0] data, input logic [31:0] addr);
    remote_req_s r;
    r.write_not_read = wnr;  r.is_amo_op = amo;  r.is_uncached_op = 1'($urandom_range(0, 1));
    r.amo_type = bsg_vanilla_amo_type_e'(at);  r.mask = mask;  r.load_info = load_info_s'(li);
    r.reg_id = rid;  r.data = data;  r.addr = addr;
    return r;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the write.
  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d; ref_mem[a] = d;
    @(negedge clk_i); bd_we = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic send(input remote_req_s r, input bit model);
    bit ok = 0;
    cur_req = r; req_v_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (req_ready_o) begin ok = 1; @(posedge clk_i); break; end
      @(negedge clk_i);
    end
    @(negedge clk_i);
    req_v_i = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL accept_timeout: request not accepted within 50 cycles"); end
    else if (model) model_apply(r);
  endtask

  task automatic wait_resp(output bit ok);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_v_o === 1'b1) begin ok = 1; break; end
      @(negedge clk_i);
    end
  endtask

  task automatic take_resp(output remote_load_resp_s r);
    r = resp_o; resp_yumi_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    resp_yumi_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      checks++;
      if ({req_ready_o, mem_v_o, resp_v_o, store_ack_o} !== 4'b0000) begin
        errors++; $display("FAIL reset_outputs: got %b want 0000", {req_ready_o, mem_v_o, resp_v_o, store_ack_o});
      end
    end
    reset_n_i = 1'b1; #1;
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready_o); end
    $display("reset done ready=%b", req_ready_o);
  endtask

  task automatic test_store();
    poke(10'h10, 32'h11223344);
    send(mk(1, 0, 0, 4'b0011, 0, 0, 32'hDEADBEEF, 32'h40), 1);
    checks++;
    if (store_ack_o !== 1'b1) begin errors++; $display("FAIL store_ack: got %b want 1", store_ack_o); end
    checks++;
    if (sram[10'h10] !== 32'h1122BEEF) begin errors++; $display("FAIL store_word: got %h want 1122beef", sram[10'h10]); end
    @(negedge clk_i);
    checks++;
    if ({store_ack_o, resp_v_o} !== 2'b00) begin errors++; $display("FAIL store_after: ack/resp got %b want 00", {store_ack_o, resp_v_o}); end
    $display("store addr=40 word=%h", sram[10'h10]);
  endtask

  task automatic test_load();
    remote_load_resp_s r, e;
    send(mk(0, 0, 0, 4'h0, 6'b001010, 5'd5, 32'h0, 32'h40), 1);
    checks++;
    if (resp_v_o !== 1'b0) begin errors++; $display("FAIL load_early: resp_v got %b want 0 at accept+1", resp_v_o); end
    @(negedge clk_i);
    checks++;
    if (resp_v_o !== 1'b1) begin errors++; $display("FAIL load_latency: resp_v got %b want 1 at accept+2", resp_v_o); end
    take_resp(r);
    e = exp_q.pop_front();
    checks++;
    if (r !== e || r.data !== 32'h1122BEEF || r.reg_id !== 5'd5 || r.part_sel !== 2'd2 || r.is_byte_op !== 1'b1) begin
      errors++; $display("FAIL load_resp: got %h want %h", r, e);
    end
    $display("load resp data=%h reg=%0d part=%0d", r.data, r.reg_id, r.part_sel);
  endtask

  task automatic test_amo();
    remote_load_resp_s r, e;
    logic [9:0]  w   [3] = '{10'h20, 10'h21, 10'h22};
    logic [31:0] ini [3] = '{32'hFFFFFFFF, 32'h0000000F, 32'hCAFE0001};
    logic [31:0] opd [3] = '{32'h1, 32'hF0, 32'h7};
    logic [1:0]  typ [3] = '{2'b10, 2'b01, 2'b00};
    logic [31:0] fin [3] = '{32'h0, 32'hFF, 32'h7};
    bit ok;
    for (int k = 0; k < 3; k++) begin
      poke(w[k], ini[k]);
      send(mk(1, 1, typ[k], 4'hF, 0, 5'(k + 9), opd[k], {20'h0, w[k], 2'b00}), 1);
      if (k == 0) begin
        checks++;
        if (resp_v_o !== 1'b0) begin errors++; $display("FAIL amo_early1: resp_v got %b want 0", resp_v_o); end
        @(negedge clk_i);
        checks++;
        if ({resp_v_o, mem_v_o, mem_w_o, mem_mask_o} !== 7'b0_1_1_1111) begin
          errors++; $display("FAIL amo_write_cycle: got %b want 0111111", {resp_v_o, mem_v_o, mem_w_o, mem_mask_o});
        end
        @(negedge clk_i);
        checks++;
        if (resp_v_o !== 1'b1) begin errors++; $display("FAIL amo_latency: resp_v got %b want 1 at accept+3", resp_v_o); end
      end
      wait_resp(ok);
      take_resp(r);
      e = exp_q.pop_front();
      checks++;
      if (!ok || r !== e || r.data !== ini[k]) begin errors++; $display("FAIL amo_resp%0d: got %h want %h", k, r, e); end
      checks++;
      if (sram[w[k]] !== fin[k]) begin errors++; $display("FAIL amo_mem%0d: got %h want %h", k, sram[w[k]], fin[k]); end
      $display("amo type=%0d old=%h new=%h", typ[k], r.data, sram[w[k]]);
    end
  endtask

  task automatic test_fifo_full();
    remote_load_resp_s r, e;
    remote_req_s c;
    bit ok;
    for (int k = 0; k < 3; k++) poke(10'(10'h30 + k), $urandom());
    send(mk(0, 0, 0, 0, 6'b100000, 5'd1, 0, 32'h0C0), 1);
    @(negedge clk_i);
    send(mk(0, 0, 0, 0, 6'b010001, 5'd2, 0, 32'h0C4), 1);
    @(negedge clk_i);
    c = mk(0, 0, 0, 0, 6'b000111, 5'd3, 0, 32'h0C8);
    cur_req = c; req_v_i = 1'b1; #1;
    checks++;
    if (req_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", req_ready_o); end
    @(negedge clk_i); #1;
    checks++;
    if (req_ready_o !== 1'b0 || resp_v_o !== 1'b1) begin
      errors++; $display("FAIL full_hold: ready=%b resp_v=%b want 0/1", req_ready_o, resp_v_o);
    end
    take_resp(r);
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL full_release: ready got %b want 1", req_ready_o); end
    @(posedge clk_i); @(negedge clk_i);
    req_v_i = 1'b0;
    model_apply(c);
    e = exp_q.pop_front();
    checks++;
    if (r !== e) begin errors++; $display("FAIL full_order0: got %h want %h", r, e); end
    for (int k = 1; k < 3; k++) begin
      wait_resp(ok);
      take_resp(r);
      e = exp_q.pop_front();
      checks++;
      if (!ok || r !== e) begin errors++; $display("FAIL full_order%0d: got %h want %h", k, r, e); end
    end
    $display("fifo full: three loads returned, last data=%h", r.data);
  endtask

  task automatic test_back_to_back();
    int ack0, acc0, bad;
    remote_req_s q;
    for (int k = 0; k < 10; k++) poke(10'(10'h40 + k), $urandom());
    ack0 = ack_cnt; acc0 = acc_cnt; bad = 0;
    for (int k = 0; k < 10; k++) begin
      q = mk(1, 0, 0, 4'($urandom()), 0, 0, $urandom(), {20'h0, 10'(10'h40 + k), 2'b00});
      cur_req = q; req_v_i = 1'b1; model_apply(q); #1;
      checks++;
      if (req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", k, req_ready_o); end
      @(negedge clk_i);
    end
    req_v_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if (ack_cnt - ack0 != 10 || acc_cnt - acc0 != 10) begin
      errors++; $display("FAIL b2b_counts: acks=%0d accepts=%0d want 10/10", ack_cnt - ack0, acc_cnt - acc0);
    end
    for (int k = 0; k < 10; k++) if (sram[10'h40 + k] !== ref_mem[10'h40 + k]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL b2b_mem: %0d words differ want 0", bad); end
    $display("back-to-back: acks=%0d accepts=%0d", ack_cnt - ack0, acc_cnt - acc0);
  endtask

  task automatic test_random();
    remote_load_resp_s r, e;
    remote_req_s q;
    logic [31:0] rnd;
    int op, bad;
    bit ok;
    for (int k = 0; k < 8; k++) poke(10'(10'h50 + k), $urandom());
    for (int n = 0; n < 60; n++) begin
      op  = $urandom_range(0, 2);
      rnd = $urandom();
      q = mk(op == 0 ? 1'b1 : (op == 2 ? 1'($urandom_range(0, 1)) : 1'b0), op == 2,
             2'($urandom_range(0, 2)), 4'($urandom()), 6'($urandom()), 5'($urandom()),
             $urandom(), {rnd[31:12], 10'(10'h50 + $urandom_range(0, 7)), rnd[1:0]});
      send(q, 1);
      if (op == 0) begin
        checks++;
        if (store_ack_o !== 1'b1) begin errors++; $display("FAIL rnd_ack%0d: got %b want 1", n, store_ack_o); end
        $display("rnd %0d store addr=%h", n, q.addr);
      end else begin
        wait_resp(ok);
        repeat ($urandom_range(0, 2)) @(negedge clk_i);
        take_resp(r);
        e = exp_q.pop_front();
        checks++;
        if (!ok || r !== e) begin errors++; $display("FAIL rnd_resp%0d: got %h want %h", n, r, e); end
        $display("rnd %0d %s addr=%h data=%h", n, op == 2 ? "amo" : "load", q.addr, r.data);
      end
    end
    bad = 0;
    for (int k = 0; k < 8; k++) if (sram[10'h50 + k] !== ref_mem[10'h50 + k]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rnd_mem: %0d words differ want 0", bad); end
  endtask

  task automatic test_reset_amo();
    remote_load_resp_s r;
    int bad0;
    bit ok;
    poke(10'h60, 32'h12345678);
    bad0 = bad_reset_wr;
    send(mk(1, 1, 2'b10, 4'hF, 0, 5'd7, 32'h1, 32'h180), 0);
    @(negedge clk_i);
    reset_n_i = 1'b0; #1;
    checks++;
    if (mem_v_o !== 1'b0 || resp_v_o !== 1'b0) begin
      errors++; $display("FAIL rst_amo_outputs: mem_v=%b resp_v=%b want 0/0", mem_v_o, resp_v_o);
    end
    @(negedge clk_i);
    reset_n_i = 1'b1; #1;
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_amo_idle: ready got %b want 1", req_ready_o); end
    repeat (3) @(negedge clk_i);
    checks++;
    if (resp_v_o !== 1'b0 || sram[10'h60] !== 32'h12345678 || bad_reset_wr != bad0) begin
      errors++; $display("FAIL rst_amo_effect: resp_v=%b word=%h resetwr=%0d want 0/12345678/0",
                         resp_v_o, sram[10'h60], bad_reset_wr - bad0);
    end
    send(mk(0, 0, 0, 0, 0, 5'd4, 0, 32'h180), 1);
    wait_resp(ok);
    take_resp(r);
    checks++;
    if (!ok || r.data !== 32'h12345678 || exp_q.pop_front() !== r) begin
      errors++; $display("FAIL rst_amo_reload: got %h want data 12345678", r);
    end
    $display("reset in AMO write: word=%h", sram[10'h60]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store();
    test_load();
    test_amo();
    test_fifo_full();
    test_back_to_back();
    test_random();
    test_reset_amo();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_resp: %0d expected responses unseen", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
